// File: rtl/ai_switch_cfg_ctrl.sv
// Management-domain configuration controller: mgmt register decode, shadow/active
// routing and QoS tables with an atomic req/ack commit, and coherent telemetry snapshots.
module ai_switch_cfg_ctrl #(
    parameter int N_PORTS   = 4,
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                           mgmt_clk,
    input  logic                           mgmt_rst_n,
    input  logic                           mgmt_sel,
    input  logic [7:0]                     mgmt_addr,
    input  logic [31:0]                    mgmt_wdata,
    input  logic                           mgmt_write,
    output logic [31:0]                    mgmt_rdata,
    output logic [N_PORTS*N_PORTS-1:0]     route_tbl,
    output logic [2*N_PORTS-1:0]           qos_tbl,
    output logic                           cfg_req,
    input  logic                           cfg_ack,
    input  logic [N_PORTS*CNT_WIDTH-1:0]   tele_in,
    input  logic [N_PORTS*CNT_WIDTH-1:0]   tele_out,
    input  logic [N_PORTS*CNT_WIDTH-1:0]   tele_drop,
    output logic                           busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [15:0]                  r_wait;
    logic [15:0]                  r_cnt;
    logic                         r_err;
    logic                         r_req;
    logic                         r_busy;
    logic [31:0]                  r_rdata;
    logic [31:0]                  w_rdata;
    logic [N_PORTS*N_PORTS-1:0]   r_route_tbl;
    logic [2*N_PORTS-1:0]         r_qos_tbl;
    logic [N_PORTS-1:0]           r_shadow_route [N_PORTS];
    logic [1:0]                   r_shadow_qos   [N_PORTS];
    logic [CNT_WIDTH-1:0]         r_snap_in      [N_PORTS];
    logic [CNT_WIDTH-1:0]         r_snap_out     [N_PORTS];
    logic [CNT_WIDTH-1:0]         r_snap_drop    [N_PORTS];

    logic w_wr;
    logic w_rd;
    logic w_commit_stb;
    logic w_snap_stb;
    logic w_do_commit;
    logic w_do_abort;
    logic [3:0] w_idx;
    logic [3:0] w_idx3;
    logic w_unused;

    assign w_wr         = mgmt_sel & mgmt_write;
    assign w_rd         = mgmt_sel & ~mgmt_write;
    assign w_commit_stb = w_wr & (mgmt_addr == 8'h00) & mgmt_wdata[0];
    assign w_snap_stb   = w_wr & (mgmt_addr == 8'h00) & mgmt_wdata[1];
    assign w_idx        = mgmt_addr[3:0];
    assign w_idx3       = {1'b0, mgmt_addr[2:0]};
    assign w_unused     = &{1'b0, mgmt_wdata[31:N_PORTS]};

    // Commit FSM next-state; ack takes priority over the timeout on the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_do_commit = 1'b0;
        w_do_abort  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_commit_stb) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cfg_ack) begin
                    w_do_commit = 1'b1;
                    w_state_nxt = ST_REL;
                end else if (r_wait == 16'(TIMEOUT - 1)) begin
                    w_do_abort  = 1'b1;
                    w_state_nxt = ST_REL;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REL: begin
                if (!cfg_ack) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, handshake outputs, wait counter, commit count, sticky error, active tables
    always_ff @(posedge mgmt_clk or negedge mgmt_rst_n) begin
        if (!mgmt_rst_n) begin
            r_state     <= ST_IDLE;
            r_wait      <= 16'd0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= 16'd0;
            r_err       <= 1'b0;
            r_route_tbl <= '0;
            r_qos_tbl   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == ST_REQ);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_wait  <= (r_state == ST_REQ) ? r_wait + 16'd1 : 16'd0;
            if (w_do_commit) begin
                r_cnt <= r_cnt + 16'd1;
                for (int i = 0; i < N_PORTS; i++) begin
                    r_route_tbl[i*N_PORTS +: N_PORTS] <= r_shadow_route[i];
                    r_qos_tbl[2*i +: 2]               <= r_shadow_qos[i];
                end
            end
            if (w_do_abort) begin
                r_err <= 1'b1;
            end else if (w_wr && (mgmt_addr == 8'h01)) begin
                r_err <= 1'b0;
            end
        end
    end

    // Shadow table writes, accepted in any FSM state
    always_ff @(posedge mgmt_clk or negedge mgmt_rst_n) begin
        if (!mgmt_rst_n) begin
            for (int i = 0; i < N_PORTS; i++) begin
                r_shadow_route[i] <= '0;
                r_shadow_qos[i]   <= 2'd0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (w_wr && (mgmt_addr == 8'h10 + 8'(i))) begin
                    r_shadow_route[i] <= mgmt_wdata[N_PORTS-1:0];
                end
                if (w_wr && (mgmt_addr == 8'h20 + 8'(i))) begin
                    r_shadow_qos[i] <= mgmt_wdata[1:0];
                end
            end
        end
    end

    // Telemetry snapshot: all ports captured on the same edge
    always_ff @(posedge mgmt_clk or negedge mgmt_rst_n) begin
        if (!mgmt_rst_n) begin
            for (int i = 0; i < N_PORTS; i++) begin
                r_snap_in[i]   <= '0;
                r_snap_out[i]  <= '0;
                r_snap_drop[i] <= '0;
            end
        end else if (w_snap_stb) begin
            for (int i = 0; i < N_PORTS; i++) begin
                r_snap_in[i]   <= tele_in[i*CNT_WIDTH +: CNT_WIDTH];
                r_snap_out[i]  <= tele_out[i*CNT_WIDTH +: CNT_WIDTH];
                r_snap_drop[i] <= tele_drop[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    // Read decode; an index with no matching port leaves the value at zero
    always_comb begin
        w_rdata = 32'd0;
        case (mgmt_addr[7:4])
            4'h0: begin
                if (mgmt_addr[3:0] == 4'h0) begin
                    w_rdata = {30'd0, r_err, r_busy};
                end else if (mgmt_addr[3:0] == 4'h1) begin
                    w_rdata = {16'd0, r_cnt};
                end else begin
                    w_rdata = 32'd0;
                end
            end
            4'h1: for (int i = 0; i < N_PORTS; i++)
                w_rdata = (w_idx == 4'(i)) ? 32'(r_shadow_route[i]) : w_rdata;
            4'h2: for (int i = 0; i < N_PORTS; i++)
                w_rdata = (w_idx == 4'(i)) ? 32'(r_shadow_qos[i]) : w_rdata;
            4'h3: for (int i = 0; i < N_PORTS; i++)
                w_rdata = (w_idx3 != 4'(i)) ? w_rdata :
                          mgmt_addr[3] ? 32'(r_qos_tbl[2*i +: 2]) :
                                         32'(r_route_tbl[i*N_PORTS +: N_PORTS]);
            4'h4: for (int i = 0; i < N_PORTS; i++)
                w_rdata = (w_idx == 4'(i)) ? 32'(r_snap_in[i]) : w_rdata;
            4'h5: for (int i = 0; i < N_PORTS; i++)
                w_rdata = (w_idx == 4'(i)) ? 32'(r_snap_out[i]) : w_rdata;
            4'h6: for (int i = 0; i < N_PORTS; i++)
                w_rdata = (w_idx == 4'(i)) ? 32'(r_snap_drop[i]) : w_rdata;
            default: w_rdata = 32'd0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge mgmt_clk or negedge mgmt_rst_n) begin
        if (!mgmt_rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_rd) begin
            r_rdata <= w_rdata;
        end
    end

    assign mgmt_rdata = r_rdata;
    assign route_tbl  = r_route_tbl;
    assign qos_tbl    = r_qos_tbl;
    assign cfg_req    = r_req;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ai_switch_cfg_ctrl.sv
// Randomized directed bench for ai_switch_cfg_ctrl against a register-map level model.
module tb_ai_switch_cfg_ctrl;
    localparam int NP = 4;
    localparam int CW = 32;
    localparam int TO = 8;

    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0, wr_en = 1'b0, ack = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [NP*NP-1:0] route;
    logic [2*NP-1:0]  qos;
    logic req, busy;
    logic [NP*CW-1:0] t_in = '0, t_out = '0, t_drop = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] m_sh_route [NP], m_sh_qos [NP], m_act_route [NP], m_act_qos [NP];
    logic [31:0] m_snap_in [NP], m_snap_out [NP], m_snap_drop [NP];
    logic [15:0] m_cnt;
    logic        m_err;
    logic [31:0] route_mask;

    ai_switch_cfg_ctrl #(.N_PORTS(NP), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .mgmt_clk(clk), .mgmt_rst_n(rst_n), .mgmt_sel(sel), .mgmt_addr(addr),
        .mgmt_wdata(wdata), .mgmt_write(wr_en), .mgmt_rdata(rdata),
        .route_tbl(route), .qos_tbl(qos), .cfg_req(req), .cfg_ack(ack),
        .tele_in(t_in), .tele_out(t_out), .tele_drop(t_drop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NP; i++) begin
            m_sh_route[i] = 32'd0; m_sh_qos[i] = 32'd0;
            m_act_route[i] = 32'd0; m_act_qos[i] = 32'd0;
            m_snap_in[i] = 32'd0; m_snap_out[i] = 32'd0; m_snap_drop[i] = 32'd0;
        end
        m_cnt = 16'd0;
        m_err = 1'b0;
    endtask

    task automatic m_commit();
        for (int i = 0; i < NP; i++) begin
            m_act_route[i] = m_sh_route[i];
            m_act_qos[i]   = m_sh_qos[i];
        end
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int k;
        sel = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wr_en = 1'b0;
        k = int'(a);
        if (k >= 16 && k < 16 + NP) m_sh_route[k-16] = d & route_mask;
        if (k >= 32 && k < 32 + NP) m_sh_qos[k-32] = d & 32'h3;
        if (k == 1) m_err = 1'b0;
        if (k == 0 && d[1]) begin
            for (int i = 0; i < NP; i++) begin
                m_snap_in[i]   = t_in[i*CW +: CW];
                m_snap_out[i]  = t_out[i*CW +: CW];
                m_snap_drop[i] = t_drop[i*CW +: CW];
            end
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        sel = 1'b1; wr_en = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        d = rdata;
    endtask

    function automatic logic [31:0] mread(input logic [7:0] a);
        int i;
        int j;
        i = int'(a[3:0]);
        j = int'(a[2:0]);
        case (a[7:4])
            4'h0: return (a[3:0] == 4'h0) ? {30'd0, m_err, 1'b0} :
                          (a[3:0] == 4'h1) ? {16'd0, m_cnt} : 32'd0;
            4'h1: return (i < NP) ? m_sh_route[i] : 32'd0;
            4'h2: return (i < NP) ? m_sh_qos[i] : 32'd0;
            4'h3: return (j >= NP) ? 32'd0 : (a[3] ? m_act_qos[j] : m_act_route[j]);
            4'h4: return (i < NP) ? m_snap_in[i] : 32'd0;
            4'h5: return (i < NP) ? m_snap_out[i] : 32'd0;
            4'h6: return (i < NP) ? m_snap_drop[i] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_route();
        logic [NP*NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i*NP +: NP] = m_act_route[i][NP-1:0];
        return 32'(r);
    endfunction

    function automatic logic [31:0] exp_qos();
        logic [2*NP-1:0] q;
        for (int i = 0; i < NP; i++) q[2*i +: 2] = m_act_qos[i][1:0];
        return 32'(q);
    endfunction

    task automatic rand_tele();
        for (int i = 0; i < NP; i++) begin
            t_in[i*CW +: CW]   = $urandom;
            t_out[i*CW +: CW]  = $urandom;
            t_drop[i*CW +: CW] = $urandom;
        end
    endtask

    task automatic rand_shadows();
        for (int i = 0; i < NP; i++) begin
            wr(8'h10 + 8'(i), $urandom);
            wr(8'h20 + 8'(i), $urandom);
        end
    endtask

    task automatic do_commit(input int d, input int hold);
        wr(8'h00, 32'h1);
        chk("commit_req_rise", 32'(req), 32'd1);
        chk("commit_busy_rise", 32'(busy), 32'd1);
        repeat (d) tick();
        chk("commit_pre_ack_route", 32'(route), exp_route());
        ack = 1'b1;
        tick();
        m_commit();
        chk("commit_route", 32'(route), exp_route());
        chk("commit_qos", 32'(qos), exp_qos());
        chk("commit_req_fall", 32'(req), 32'd0);
        repeat (hold) tick();
        chk("rel_busy_held", 32'(busy), 32'd1);
        ack = 1'b0;
        tick();
        chk("rel_busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic sweep_reads(input string tag);
        logic [31:0] v;
        logic [7:0]  a;
        for (int n = 0; n < 10; n++) begin
            a = 8'($urandom_range(0, 127));
            if (n < 4) a = 8'h30 + 8'(n);
            rd(a, v);
            chk(tag, v, mread(a));
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] held;
        logic [15:0] cnt_before;
        int n;

        route_mask = (32'd1 << NP) - 32'd1;
        m_reset();
        repeat (3) tick();
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_route", 32'(route), 32'd0);
        chk("rst_qos", 32'(qos), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic commit
        wr(8'h10, 32'h6);
        wr(8'h21, 32'h3);
        do_commit(3, 1);
        chk("basic_route_p0", 32'(route[3:0]), 32'h6);
        chk("basic_qos_p1", 32'(qos[3:2]), 32'h3);
        rd(8'h01, v);
        chk("basic_commit_cnt", v, 32'd1);

        // Randomized commits
        for (int it = 0; it < 4; it++) begin
            rand_shadows();
            do_commit(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
            sweep_reads("rand_read");
        end

        // Shadow write and second COMMIT while in REQ
        wr(8'h10, 32'h5);
        cnt_before = m_cnt;
        wr(8'h00, 32'h1);
        wr(8'h10, 32'hF);
        wr(8'h00, 32'h1);
        ack = 1'b1;
        tick();
        m_commit();
        ack = 1'b0;
        tick();
        chk("req_shadow_route", 32'(route[3:0]), 32'hF);
        rd(8'h01, v);
        chk("req_double_commit_cnt", v, {16'd0, cnt_before + 16'd1});

        // Timeout abort
        wr(8'h00, 32'h1);
        n = 0;
        while (req === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("timeout_len", 32'(n), 32'(TO));
        m_err = 1'b1;
        chk("timeout_route", 32'(route), exp_route());
        chk("timeout_qos", 32'(qos), exp_qos());
        tick();
        chk("timeout_busy", 32'(busy), 32'd0);
        rd(8'h00, v);
        chk("timeout_status", v, 32'h2);
        wr(8'h01, $urandom);
        rd(8'h00, v);
        chk("err_clear_status", v, 32'h0);

        // Snapshot coherence
        rand_tele();
        t_drop[2*CW +: CW] = 32'h1234;
        wr(8'h00, 32'h2);
        rand_tele();
        t_drop[2*CW +: CW] = 32'h9999;
        rd(8'h62, v);
        chk("snap_drop_p2", v, 32'h1234);
        for (int i = 0; i < NP; i++) begin
            rd(8'h40 + 8'(i), v); chk("snap_in", v, mread(8'h40 + 8'(i)));
            rd(8'h50 + 8'(i), v); chk("snap_out", v, mread(8'h50 + 8'(i)));
        end

        // COMMIT and SNAP in one write
        rand_shadows();
        rand_tele();
        wr(8'h00, 32'h3);
        chk("combo_req", 32'(req), 32'd1);
        rand_tele();
        ack = 1'b1;
        tick();
        m_commit();
        ack = 1'b0;
        tick();
        chk("combo_route", 32'(route), exp_route());
        rd(8'h61, v);
        chk("combo_snap", v, mread(8'h61));

        // Decode edges and read-data hold
        rd(8'h10 + 8'(NP), v);
        chk("oob_shadow_read", v, 32'd0);
        rd(8'h7F, v);
        chk("unmapped_read", v, 32'd0);
        wr(8'h30, 32'hFFFF_FFFF);
        rd(8'h30, v);
        chk("active_ro_read", v, mread(8'h30));
        chk("active_ro_route", 32'(route), exp_route());
        held = v;
        tick();
        tick();
        chk("rdata_hold", rdata, held);

        // Reset in the middle of REQ
        rd(8'h01, v);
        wr(8'h00, 32'h1);
        tick();
        chk("pre_rst_req", 32'(req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_route", 32'(route), 32'd0);
        chk("midrst_qos", 32'(qos), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        m_reset();
        tick();
        rst_n = 1'b1;
        tick();
        rd(8'h10, v);
        chk("post_rst_shadow", v, 32'd0);
        rd(8'h01, v);
        chk("post_rst_cnt", v, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
